// File: rtl/hdng_pid_if.sv
// Heading PID bus: heading samples, drive enable and forward speed in;
// wheel speed commands and settled flag out.
//   master : drives actl_hdng, dsrd_hdng, hdng_vld, moving, frwrd_spd
//   slave  : drives lft_spd, rght_spd, at_hdng
interface hdng_pid_if #(
  parameter int HDNG_W = 12,
  parameter int SPD_W  = 11
);
  logic signed [HDNG_W-1:0] actl_hdng;
  logic signed [HDNG_W-1:0] dsrd_hdng;
  logic                     hdng_vld;
  logic                     moving;
  logic        [SPD_W-1:0]  frwrd_spd;
  logic signed [SPD_W:0]    lft_spd;
  logic signed [SPD_W:0]    rght_spd;
  logic                     at_hdng;

  modport master (
    output actl_hdng, dsrd_hdng, hdng_vld, moving, frwrd_spd,
    input  lft_spd, rght_spd, at_hdng
  );

  modport slave (
    input  actl_hdng, dsrd_hdng, hdng_vld, moving, frwrd_spd,
    output lft_spd, rght_spd, at_hdng
  );
endinterface

// File: rtl/hdng_pid.sv
// Heading PID controller, three register stages:
//   1: saturated heading error
//   2: P, D (look-back difference) and saturating integrator
//   3: differential wheel commands around the forward speed
// A settle counter raises at_hdng after SETTLE consecutive in-band samples.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - hdng_pid_if slave (heading inputs, speed outputs, at_hdng)
module hdng_pid #(
  parameter int          HDNG_W    = 12,
  parameter int          ERR_W     = 10,
  parameter int          SPD_W     = 11,
  parameter int unsigned P_COEFF   = 3,
  parameter int unsigned D_COEFF   = 14,
  parameter int unsigned D_LAG     = 2,
  parameter int unsigned I_SHIFT   = 4,
  parameter int unsigned AT_THRESH = 30,
  parameter int unsigned SETTLE    = 4
) (
  input  logic      clk,
  input  logic      rst,
  hdng_pid_if.slave bus
);

  localparam int CW = ERR_W + 8;
  localparam int IW = ERR_W + 6;
  localparam int OW = ((CW > SPD_W + 1) ? CW : SPD_W + 1) + 2;

  if (D_LAG == 0 || D_LAG > 8) begin : g_bad_dlag
    $error("hdng_pid: D_LAG must be in 1..8");
  end
  if (SETTLE == 0 || SETTLE > 15) begin : g_bad_settle
    $error("hdng_pid: SETTLE must be in 1..15");
  end

  localparam logic signed [HDNG_W-1:0] E_MAX  = HDNG_W'((1 << (ERR_W - 1)) - 1);
  localparam logic signed [HDNG_W-1:0] E_MIN  = ~E_MAX;
  localparam logic signed [ERR_W:0]    D8_MAX = (ERR_W + 1)'(127);
  localparam logic signed [ERR_W:0]    D8_MIN = ~D8_MAX;
  localparam logic signed [IW:0]       I_MAX  = (IW + 1)'((1 << (IW - 1)) - 1);
  localparam logic signed [IW:0]       I_MIN  = ~I_MAX;
  localparam logic signed [OW-1:0]     O_MAX  = OW'((1 << SPD_W) - 1);
  localparam logic signed [OW-1:0]     O_MIN  = ~O_MAX;
  localparam logic signed [CW-1:0]     P_K    = CW'(P_COEFF);
  localparam logic signed [CW-1:0]     D_K    = CW'(D_COEFF);
  localparam logic signed [ERR_W-1:0]  AT_P   = ERR_W'(AT_THRESH);
  localparam logic signed [ERR_W-1:0]  AT_N   = -AT_P;
  localparam logic        [3:0]        SET_K  = 4'(SETTLE);

  logic signed [ERR_W-1:0]  r_err_sat;
  logic signed [ERR_W-1:0]  r_hist [D_LAG];
  logic signed [CW-1:0]     r_p;
  logic signed [CW-1:0]     r_d;
  logic signed [IW-1:0]     r_integ;
  logic signed [SPD_W:0]    r_lft;
  logic signed [SPD_W:0]    r_rght;
  logic        [3:0]        r_cnt;
  logic                     r_at;

  logic signed [HDNG_W-1:0] w_err;
  logic signed [ERR_W-1:0]  w_err_sat;
  logic signed [ERR_W:0]    w_diff;
  logic signed [7:0]        w_diff8;
  logic signed [IW:0]       w_isum;
  logic signed [IW-1:0]     w_integ_nxt;
  logic signed [CW-1:0]     w_i;
  logic signed [CW-1:0]     w_corr;
  logic signed [OW-1:0]     w_fw;
  logic signed [OW-1:0]     w_l;
  logic signed [OW-1:0]     w_r;
  logic signed [SPD_W:0]    w_l_sat;
  logic signed [SPD_W:0]    w_r_sat;
  logic                     w_in_band;

  // Difference taken at HDNG_W bits so it wraps around the heading circle.
  assign w_err     = bus.actl_hdng - bus.dsrd_hdng;
  assign w_diff    = (ERR_W + 1)'(r_err_sat) - (ERR_W + 1)'(r_hist[D_LAG-1]);
  assign w_isum    = (IW + 1)'(r_integ) + (IW + 1)'(r_err_sat);
  assign w_i       = CW'(r_integ >>> I_SHIFT);
  assign w_corr    = (r_p + r_d + w_i) >>> 3;
  assign w_fw      = OW'({1'b0, bus.frwrd_spd});
  assign w_l       = w_fw + OW'(w_corr);
  assign w_r       = w_fw - OW'(w_corr);
  assign w_in_band = (r_err_sat > AT_N) && (r_err_sat < AT_P);

  always_comb begin
    w_err_sat = ERR_W'(w_err);
    if (w_err > E_MAX)      w_err_sat = ERR_W'(E_MAX);
    else if (w_err < E_MIN) w_err_sat = ERR_W'(E_MIN);

    w_diff8 = 8'(w_diff);
    if (w_diff > D8_MAX)      w_diff8 = 8'sd127;
    else if (w_diff < D8_MIN) w_diff8 = -8'sd128;

    w_integ_nxt = IW'(w_isum);
    if (w_isum > I_MAX)      w_integ_nxt = IW'(I_MAX);
    else if (w_isum < I_MIN) w_integ_nxt = IW'(I_MIN);

    w_l_sat = (SPD_W + 1)'(w_l);
    if (w_l > O_MAX)      w_l_sat = (SPD_W + 1)'(O_MAX);
    else if (w_l < O_MIN) w_l_sat = (SPD_W + 1)'(O_MIN);

    w_r_sat = (SPD_W + 1)'(w_r);
    if (w_r > O_MAX)      w_r_sat = (SPD_W + 1)'(O_MAX);
    else if (w_r < O_MIN) w_r_sat = (SPD_W + 1)'(O_MIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sat <= '0;
      r_p       <= '0;
      r_d       <= '0;
      r_integ   <= '0;
      r_lft     <= '0;
      r_rght    <= '0;
      r_cnt     <= '0;
      r_at      <= 1'b0;
      for (int unsigned i = 0; i < D_LAG; i++) r_hist[i] <= '0;
    end else begin
      r_err_sat <= w_err_sat;
      r_p       <= P_K * CW'(r_err_sat);
      r_d       <= D_K * CW'(w_diff8);

      if (bus.hdng_vld) begin
        r_hist[0] <= r_err_sat;
        for (int unsigned i = 1; i < D_LAG; i++) r_hist[i] <= r_hist[i-1];
      end

      if (!bus.moving)       r_integ <= '0;
      else if (bus.hdng_vld) r_integ <= w_integ_nxt;

      r_lft  <= bus.moving ? w_l_sat : '0;
      r_rght <= bus.moving ? w_r_sat : '0;

      if (bus.hdng_vld) begin
        if (!w_in_band)          r_cnt <= '0;
        else if (r_cnt != SET_K) r_cnt <= r_cnt + 4'd1;
      end
      r_at <= (r_cnt == SET_K);
    end
  end

  assign bus.lft_spd  = r_lft;
  assign bus.rght_spd = r_rght;
  assign bus.at_hdng  = r_at;

endmodule

// File: tb/tb_hdng_pid.sv
module tb_hdng_pid;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hdng_pid_if #(.HDNG_W(12), .SPD_W(11)) u_if ();

  hdng_pid #(
    .HDNG_W(12), .ERR_W(10), .SPD_W(11), .P_COEFF(3), .D_COEFF(14),
    .D_LAG(2), .I_SHIFT(4), .AT_THRESH(30), .SETTLE(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [11:0] a, input logic [11:0] d, input logic [10:0] f,
                       input logic mv, input logic vld);
    u_if.actl_hdng = a;
    u_if.dsrd_hdng = d;
    u_if.frwrd_spd = f;
    u_if.moving    = mv;
    u_if.hdng_vld  = vld;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(12'h000, 12'h000, 11'h000, 1'b0, 1'b0);
    do_reset();
    checks++; if (u_if.lft_spd !== 12'sd0) begin errs++; $display("FAIL reset_lft: got %0d expected 0", u_if.lft_spd); end
    checks++; if (u_if.rght_spd !== 12'sd0) begin errs++; $display("FAIL reset_rght: got %0d expected 0", u_if.rght_spd); end
    checks++; if (u_if.at_hdng !== 1'b0) begin errs++; $display("FAIL reset_at: got %0b expected 0", u_if.at_hdng); end
    // Build nonzero state: 3 valid samples of err 511 then hold.
    drive(12'h400, 12'h000, 11'h100, 1'b1, 1'b1);
    tick(3);
    u_if.hdng_vld = 1'b0;
    tick(4);
    checks++; if (dut.r_integ !== 16'sd1022) begin errs++; $display("FAIL midrun_integ: got %0d expected 1022", dut.r_integ); end
    checks++; if (u_if.lft_spd !== 12'sd455) begin errs++; $display("FAIL midrun_lft: got %0d expected 455", u_if.lft_spd); end
    checks++; if (u_if.rght_spd !== 12'sd57) begin errs++; $display("FAIL midrun_rght: got %0d expected 57", u_if.rght_spd); end
    #2 rst = 1'b1;
    #1;
    checks++; if (u_if.lft_spd !== 12'sd0) begin errs++; $display("FAIL async_lft: got %0d expected 0", u_if.lft_spd); end
    checks++; if (u_if.rght_spd !== 12'sd0) begin errs++; $display("FAIL async_rght: got %0d expected 0", u_if.rght_spd); end
    checks++; if (u_if.at_hdng !== 1'b0) begin errs++; $display("FAIL async_at: got %0b expected 0", u_if.at_hdng); end
    #1 rst = 1'b0;
    tick(1);
    checks++; if (dut.r_integ !== 16'sd0) begin errs++; $display("FAIL post_rst_integ: got %0d expected 0", dut.r_integ); end
  endtask

  task automatic test_straight();
    drive(12'h000, 12'h000, 11'h000, 1'b0, 1'b0);
    do_reset();
    drive(12'h000, 12'h000, 11'h100, 1'b1, 1'b1);
    tick(3);
    checks++; if (u_if.lft_spd !== 12'sd256) begin errs++; $display("FAIL straight_lft: got %0d expected 256", u_if.lft_spd); end
    checks++; if (u_if.rght_spd !== 12'sd256) begin errs++; $display("FAIL straight_rght: got %0d expected 256", u_if.rght_spd); end
    tick(1);
    checks++; if (u_if.at_hdng !== 1'b0) begin errs++; $display("FAIL straight_at4: got %0b expected 0", u_if.at_hdng); end
    tick(1);
    checks++; if (u_if.at_hdng !== 1'b1) begin errs++; $display("FAIL straight_at5: got %0b expected 1", u_if.at_hdng); end
  endtask

  task automatic test_sat_pd();
    drive(12'h000, 12'h000, 11'h000, 1'b0, 1'b0);
    do_reset();
    drive(12'h400, 12'h000, 11'h000, 1'b1, 1'b0);
    tick(1);
    checks++; if (dut.r_err_sat !== 10'sd511) begin errs++; $display("FAIL sat_err: got %0d expected 511", dut.r_err_sat); end
    tick(1);
    checks++; if (dut.r_p !== 18'sd1533) begin errs++; $display("FAIL sat_p: got %0d expected 1533", dut.r_p); end
    checks++; if (dut.r_d !== 18'sd1778) begin errs++; $display("FAIL sat_d: got %0d expected 1778", dut.r_d); end
    checks++; if (u_if.lft_spd !== 12'sd0) begin errs++; $display("FAIL sat_latency: got %0d expected 0", u_if.lft_spd); end
    tick(1);
    checks++; if (u_if.lft_spd !== 12'sd413) begin errs++; $display("FAIL sat_lft: got %0d expected 413", u_if.lft_spd); end
    checks++; if (u_if.rght_spd !== -12'sd413) begin errs++; $display("FAIL sat_rght: got %0d expected -413", u_if.rght_spd); end
  endtask

  task automatic test_wrap();
    drive(12'h000, 12'h000, 11'h000, 1'b0, 1'b0);
    do_reset();
    drive(12'h7FF, 12'h801, 11'h000, 1'b1, 1'b1);
    tick(1);
    checks++; if (dut.r_err_sat !== -10'sd2) begin errs++; $display("FAIL wrap_err: got %0d expected -2", dut.r_err_sat); end
    tick(1);
    checks++; if (dut.r_p !== -18'sd6) begin errs++; $display("FAIL wrap_p: got %0d expected -6", dut.r_p); end
    tick(3);
    checks++; if (u_if.at_hdng !== 1'b1) begin errs++; $display("FAIL wrap_at: got %0b expected 1", u_if.at_hdng); end
  endtask

  task automatic test_settle_band();
    drive(12'h000, 12'h000, 11'h000, 1'b0, 1'b0);
    do_reset();
    drive(12'd29, 12'h000, 11'h000, 1'b1, 1'b1);
    tick(5);
    checks++; if (u_if.at_hdng !== 1'b1) begin errs++; $display("FAIL band29_at: got %0b expected 1", u_if.at_hdng); end
    u_if.actl_hdng = -12'sd30;
    tick(2);
    checks++; if (u_if.at_hdng !== 1'b1) begin errs++; $display("FAIL band30_hold: got %0b expected 1", u_if.at_hdng); end
    tick(1);
    checks++; if (u_if.at_hdng !== 1'b0) begin errs++; $display("FAIL band30_drop: got %0b expected 0", u_if.at_hdng); end
    // Counter holds while hdng_vld=0 and ignores moving.
    drive(12'h000, 12'h000, 11'h000, 1'b0, 1'b0);
    tick(6);
    checks++; if (u_if.at_hdng !== 1'b0) begin errs++; $display("FAIL vld_hold_at: got %0b expected 0", u_if.at_hdng); end
    u_if.hdng_vld = 1'b1;
    tick(4);
    checks++; if (u_if.at_hdng !== 1'b0) begin errs++; $display("FAIL settle4_at: got %0b expected 0", u_if.at_hdng); end
    tick(1);
    checks++; if (u_if.at_hdng !== 1'b1) begin errs++; $display("FAIL settle5_at: got %0b expected 1", u_if.at_hdng); end
    tick(3);
    checks++; if (u_if.at_hdng !== 1'b1) begin errs++; $display("FAIL settle_sat_at: got %0b expected 1", u_if.at_hdng); end
  endtask

  task automatic test_integ_clamp();
    drive(12'h000, 12'h000, 11'h000, 1'b0, 1'b0);
    do_reset();
    drive(12'h400, 12'h000, 11'h000, 1'b1, 1'b1);
    tick(100);
    checks++; if (dut.r_integ !== 16'sd32767) begin errs++; $display("FAIL integ_max: got %0d expected 32767", dut.r_integ); end
    checks++; if (u_if.lft_spd !== 12'sd447) begin errs++; $display("FAIL integ_lft: got %0d expected 447", u_if.lft_spd); end
    checks++; if (u_if.rght_spd !== -12'sd447) begin errs++; $display("FAIL integ_rght: got %0d expected -447", u_if.rght_spd); end
    u_if.moving = 1'b0;
    tick(1);
    checks++; if (dut.r_integ !== 16'sd0) begin errs++; $display("FAIL integ_clear: got %0d expected 0", dut.r_integ); end
    checks++; if (u_if.lft_spd !== 12'sd0) begin errs++; $display("FAIL stopped_lft: got %0d expected 0", u_if.lft_spd); end
    u_if.moving   = 1'b1;
    u_if.hdng_vld = 1'b0;
    tick(3);
    checks++; if (u_if.lft_spd !== 12'sd191) begin errs++; $display("FAIL resume_lft: got %0d expected 191", u_if.lft_spd); end
    checks++; if (u_if.rght_spd !== -12'sd191) begin errs++; $display("FAIL resume_rght: got %0d expected -191", u_if.rght_spd); end
  endtask

  task automatic test_out_clamp();
    drive(12'h000, 12'h000, 11'h000, 1'b0, 1'b0);
    do_reset();
    drive(12'h400, 12'h000, 11'd2047, 1'b1, 1'b0);
    tick(3);
    checks++; if (u_if.lft_spd !== 12'sd2047) begin errs++; $display("FAIL clamp_pos_lft: got %0d expected 2047", u_if.lft_spd); end
    checks++; if (u_if.rght_spd !== 12'sd1634) begin errs++; $display("FAIL clamp_pos_rght: got %0d expected 1634", u_if.rght_spd); end
    u_if.actl_hdng = 12'hC00;
    tick(3);
    checks++; if (u_if.lft_spd !== 12'sd1631) begin errs++; $display("FAIL clamp_neg_lft: got %0d expected 1631", u_if.lft_spd); end
    checks++; if (u_if.rght_spd !== 12'sd2047) begin errs++; $display("FAIL clamp_neg_rght: got %0d expected 2047", u_if.rght_spd); end
    u_if.frwrd_spd = 11'd0;
    tick(1);
    checks++; if (u_if.lft_spd !== -12'sd416) begin errs++; $display("FAIL neg_corr_lft: got %0d expected -416", u_if.lft_spd); end
    checks++; if (u_if.rght_spd !== 12'sd416) begin errs++; $display("FAIL neg_corr_rght: got %0d expected 416", u_if.rght_spd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(12'h000, 12'h000, 11'h000, 1'b0, 1'b0);
    test_reset();
    test_straight();
    test_sat_pd();
    test_wrap();
    test_settle_band();
    test_integ_clamp();
    test_out_clamp();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hdng_pid.md
HDNG_PID -- requirements
Module: hdng_pid

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 HDNG_W, 12, heading/error width (signed)
 ERR_W, 10, saturated-error width (signed)
 SPD_W, 11, frwrd_spd width (unsigned)
 P_COEFF, 3, proportional gain (unsigned)
 D_COEFF, 14, derivative gain (unsigned)
 D_LAG, 2, derivative look-back in hdng_vld samples, legal 1..8
 I_SHIFT, 4, integrator arithmetic right shift
 AT_THRESH, 30, at-heading error magnitude bound (exclusive)
 SETTLE, 4, consecutive in-band samples required for at_hdng, legal 1..15
REQ-002 Ports (name, direction, width, meaning), one per line:
 clk  in  1  sole clock, rising edge
 rst  in  1  asynchronous active-high reset
 actl_hdng  in  HDNG_W  measured heading, signed
 dsrd_hdng  in  HDNG_W  desired heading, signed
 hdng_vld  in  1  new heading sample strobe
 moving  in  1  drive enable
 frwrd_spd  in  SPD_W  forward speed, unsigned
 lft_spd  out  SPD_W+1  left wheel command, signed
 rght_spd  out  SPD_W+1  right wheel command, signed
 at_hdng  out  1  heading settled flag
REQ-003 One clock domain; reset is asynchronous and active-high.

Function
REQ-004 error = actl_hdng - dsrd_hdng, computed modulo 2^HDNG_W (wraps, no widening).
REQ-005 Stage 1: err_sat register = error saturated to signed ERR_W range, loaded every clock.
REQ-006 Stage 2 P: P register = P_COEFF * err_sat, signed, loaded every clock.
REQ-007 Stage 2 D: history shift register of D_LAG err_sat entries shifts only when hdng_vld=1; diff = err_sat - oldest entry, saturated to signed 8 bits; D register = diff * D_COEFF, loaded every clock.
REQ-008 Stage 2 I: signed integrator of ERR_W+6 bits; moving=0 clears it to 0; otherwise, when hdng_vld=1, adds err_sat with saturating clamp to max/min (never wraps, never freezes below limit); otherwise holds; I = integrator >>> I_SHIFT.
REQ-009 corr = (sign-extended P + I + D) >>> 3, summed in ERR_W+8 bits without overflow.
REQ-010 Stage 3: lft_spd = sat(frwrd_spd + corr), rght_spd = sat(frwrd_spd - corr), both saturated to signed SPD_W+1 range; both 0 when moving=0.
REQ-011 Latency actl_hdng/dsrd_hdng change -> lft_spd/rght_spd: 3 clocks for every term.
REQ-012 Settle counter (4 bits): on hdng_vld=1 with -AT_THRESH < err_sat < AT_THRESH increment, saturating at SETTLE; on hdng_vld=1 out of band clear to 0; hdng_vld=0 holds; independent of moving.
REQ-013 at_hdng registered, =1 exactly when counter equals SETTLE; drops the clock after an out-of-band sample.
REQ-014 Illegal D_LAG or SETTLE fails elaboration.

Reset
REQ-015 rst=1 at any time immediately forces err_sat, P, D, integrator, D history, settle counter, lft_spd, rght_spd, at_hdng to 0; operation resumes on first clock edge after rst deasserts, with no state retained.

Verification
REQ-016 Reset mid-run: moving=1, outputs nonzero, assert rst -> lft_spd=rght_spd=0, at_hdng=0 without clock; integrator reads 0 after release.
REQ-017 Straight: actl=dsrd=0, frwrd_spd=0x100, moving=1, hdng_vld=1 every clock -> lft_spd=rght_spd=256 at clock 3; at_hdng=1 at clock 5 (err_sat valid at 1, 4 samples, +1 register).
REQ-018 Saturation/P+D: actl=0x400, dsrd=0, frwrd=0, moving=1, hdng_vld=0 -> err_sat=511, P=1533, D=127*14=1778, I=0, lft_spd=413, rght_spd=-413.
REQ-019 Wrap: actl=0x7FF, dsrd=0x801 -> error=-2, err_sat=-2, P=-6, at_hdng path counts sample as in band.
REQ-020 Integrator clamp: err_sat=511, hdng_vld=1, moving=1 for 100 clocks -> integrator=32767 (no wrap), I=2047; moving=0 one clock -> integrator=0.
REQ-021 Output clamp: frwrd_spd=2047, large positive corr -> lft_spd=2047, rght_spd=2047-corr; large negative corr with frwrd_spd=0 -> rght_spd clamps at 2047.
